// File: rtl/regfile_wport_arbiter_pkg.sv
// Shared pipeline-control encodings for the register-file write port.
//   REG_W / DATA_W : default register-address and write-data widths
//   ZERO_REG       : architectural $zero; writes to it are discarded
//   wreq_t         : one write request presented to the register file
package regfile_wport_arbiter_pkg;

  localparam int REG_W  = 5;
  localparam int DATA_W = 32;

  localparam logic [REG_W-1:0] ZERO_REG = '0;

  typedef struct packed {
    logic              we;
    logic [REG_W-1:0]  waddr;
    logic [DATA_W-1:0] wdata;
  } wreq_t;

endpackage

// File: rtl/regfile_wport_arbiter_fifo.sv
// MDU result buffer for the shared register-file write port.
// Ports:
//   clk, rst_n             clock / async active-low reset
//   push, push_reg/data    accepted MDU result (reg==$zero is not stored)
//   pop                    retire the head entry (live or killed)
//   kill_en, kill_reg      pipeline write this cycle; clears live on matching entries
//   head_valid/live/reg/data  head entry view
//   full                   registered count == DEPTH
//   busy_mask              one-hot OR of destination regs of live entries
module regfile_wport_arbiter_fifo
  import regfile_wport_arbiter_pkg::*;
#(
  parameter int DEPTH  = 2,
  parameter int REG_W  = 5,
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic [REG_W-1:0]      push_reg,
  input  logic [DATA_W-1:0]     push_data,
  input  logic                  pop,
  input  logic                  kill_en,
  input  logic [REG_W-1:0]      kill_reg,
  output logic                  head_valid,
  output logic                  head_live,
  output logic [REG_W-1:0]      head_reg,
  output logic [DATA_W-1:0]     head_data,
  output logic                  full,
  output logic [2**REG_W-1:0]   busy_mask
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [PTR_W:0]    count;
  logic [DEPTH-1:0]  live_q;
  logic [REG_W-1:0]  reg_q  [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic              store;

  // A $zero result completes its handshake but occupies no slot.
  assign store = push && (push_reg != REG_W'(ZERO_REG));

  assign head_valid = (count != '0);
  assign head_live  = head_valid && live_q[rd_ptr];
  assign head_reg   = reg_q[rd_ptr];
  assign head_data  = data_q[rd_ptr];
  assign full       = (count == (PTR_W+1)'(DEPTH));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      live_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        reg_q[i]  <= '0;
        data_q[i] <= '0;
      end
    end else begin
      // Kill first so a same-cycle push to the same register still lands live.
      if (kill_en) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (reg_q[i] == kill_reg) live_q[i] <= 1'b0;
        end
      end
      if (pop) begin
        live_q[rd_ptr] <= 1'b0;
        rd_ptr         <= rd_ptr + 1'b1;
      end
      if (store) begin
        live_q[wr_ptr] <= 1'b1;
        reg_q[wr_ptr]  <= push_reg;
        data_q[wr_ptr] <= push_data;
        wr_ptr         <= wr_ptr + 1'b1;
      end
      case ({store, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_comb begin
    busy_mask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (live_q[i]) busy_mask[reg_q[i]] = 1'b1;
    end
  end

endmodule

// File: rtl/regfile_wport_arbiter.sv
// Register-file write-port arbiter: pipeline write-back always wins, MDU
// results are buffered and drained into idle slots.
// Ports:
//   clk, rst_n                       clock / async active-low reset
//   wb_RegWrite/write_reg/write_data pipeline write-back request
//   mdu_valid/reg/data, mdu_ready    MDU result handshake
//   rf_we/waddr/wdata                register-file write port
//   busy_mask                        registers with a live queued MDU result
//   stall_req                        ask hazard unit for bubbles so the head drains
module regfile_wport_arbiter #(
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4,
  parameter int DATA_W       = regfile_wport_arbiter_pkg::DATA_W,
  parameter int REG_W        = regfile_wport_arbiter_pkg::REG_W
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                wb_RegWrite,
  input  logic [REG_W-1:0]    wb_write_reg,
  input  logic [DATA_W-1:0]   wb_write_data,
  input  logic                mdu_valid,
  input  logic [REG_W-1:0]    mdu_reg,
  input  logic [DATA_W-1:0]   mdu_data,
  output logic                mdu_ready,
  output logic                rf_we,
  output logic [REG_W-1:0]    rf_waddr,
  output logic [DATA_W-1:0]   rf_wdata,
  output logic [2**REG_W-1:0] busy_mask,
  output logic                stall_req
);

  import regfile_wport_arbiter_pkg::*;

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

  logic              pipe_we;
  logic              head_valid, head_live, full, pop;
  logic [REG_W-1:0]  head_reg;
  logic [DATA_W-1:0] head_data;
  logic [CNT_W-1:0]  starve_cnt;

  assign pipe_we   = wb_RegWrite && (wb_write_reg != REG_W'(ZERO_REG));
  assign mdu_ready = !full;

  // Killed heads retire without a write, even under a pipeline write.
  assign pop = head_valid && (!head_live || !pipe_we);

  regfile_wport_arbiter_fifo #(
    .DEPTH  (DEPTH),
    .REG_W  (REG_W),
    .DATA_W (DATA_W)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (mdu_valid && mdu_ready),
    .push_reg   (mdu_reg),
    .push_data  (mdu_data),
    .pop        (pop),
    .kill_en    (pipe_we),
    .kill_reg   (wb_write_reg),
    .head_valid (head_valid),
    .head_live  (head_live),
    .head_reg   (head_reg),
    .head_data  (head_data),
    .full       (full),
    .busy_mask  (busy_mask)
  );

  // Outputs are gated by rst_n so the port goes quiet the moment reset asserts.
  always_comb begin
    rf_we    = 1'b0;
    rf_waddr = '0;
    rf_wdata = '0;
    if (rst_n) begin
      if (pipe_we) begin
        rf_we    = 1'b1;
        rf_waddr = wb_write_reg;
        rf_wdata = wb_write_data;
      end else if (head_live) begin
        rf_we    = 1'b1;
        rf_waddr = head_reg;
        rf_wdata = head_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= '0;
    end else if (!head_valid || pop) begin
      starve_cnt <= '0;
    end else if (starve_cnt != CNT_W'(STARVE_LIMIT)) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

  assign stall_req = (starve_cnt == CNT_W'(STARVE_LIMIT));

endmodule

// File: tb/tb_regfile_wport_arbiter.sv
module tb_regfile_wport_arbiter;

  logic        clk;
  logic        rst_n;
  logic        wb_RegWrite;
  logic [4:0]  wb_write_reg;
  logic [31:0] wb_write_data;
  logic        mdu_valid;
  logic [4:0]  mdu_reg;
  logic [31:0] mdu_data;
  logic        mdu_ready;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [31:0] busy_mask;
  logic        stall_req;

  int n_chk  = 0;
  int n_pass = 0;

  regfile_wport_arbiter #(
    .DEPTH        (2),
    .STARVE_LIMIT (4),
    .DATA_W       (32),
    .REG_W        (5)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .wb_RegWrite   (wb_RegWrite),
    .wb_write_reg  (wb_write_reg),
    .wb_write_data (wb_write_data),
    .mdu_valid     (mdu_valid),
    .mdu_reg       (mdu_reg),
    .mdu_data      (mdu_data),
    .mdu_ready     (mdu_ready),
    .rf_we         (rf_we),
    .rf_waddr      (rf_waddr),
    .rf_wdata      (rf_wdata),
    .busy_mask     (busy_mask),
    .stall_req     (stall_req)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic wb(input logic we, input logic [4:0] r, input logic [31:0] d);
    wb_RegWrite   = we;
    wb_write_reg  = r;
    wb_write_data = d;
  endtask

  task automatic mdu(input logic v, input logic [4:0] r, input logic [31:0] d);
    mdu_valid = v;
    mdu_reg   = r;
    mdu_data  = d;
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_port(input string tag, input logic we, input logic [4:0] a, input logic [31:0] d);
    chk({tag, ".we"},    64'(rf_we),    64'(we));
    chk({tag, ".waddr"}, 64'(rf_waddr), 64'(a));
    chk({tag, ".wdata"}, 64'(rf_wdata), 64'(d));
  endtask

  initial begin
    rst_n = 1'b0;
    wb(1'b1, 5'd3, 32'h3333);
    mdu(1'b0, 5'd0, 32'h0);
    #2;
    // Reset: port forced quiet even with a pipeline write present.
    chk_port("rst", 1'b0, 5'd0, 32'h0);
    chk("rst.busy",  64'(busy_mask), 64'h0);
    chk("rst.ready", 64'(mdu_ready), 64'h1);
    chk("rst.stall", 64'(stall_req), 64'h0);
    cyc();
    wb(1'b0, 5'd0, 32'h0);
    rst_n = 1'b1;
    cyc();

    // Idle drain of r8.
    mdu(1'b1, 5'd8, 32'h0000_1234);
    #1;
    chk("drain.ready", 64'(mdu_ready), 64'h1);
    chk("drain.empty_we", 64'(rf_we), 64'h0);
    cyc();
    mdu(1'b0, 5'd0, 32'h0);
    chk("drain.busy8", 64'(busy_mask), 64'h100);
    #1;
    chk_port("drain.wr", 1'b1, 5'd8, 32'h1234);
    cyc();
    chk("drain.busy_clr", 64'(busy_mask), 64'h0);
    chk("drain.idle_we",  64'(rf_we), 64'h0);

    // Priority and starvation: r9 waits behind five pipeline writes to r3.
    mdu(1'b1, 5'd9, 32'h9999);
    cyc();
    mdu(1'b0, 5'd0, 32'h0);
    wb(1'b1, 5'd3, 32'h0333);
    for (int k = 1; k <= 5; k++) begin
      #1;
      chk($sformatf("starve.pipe%0d.waddr", k), 64'(rf_waddr), 64'd3);
      chk($sformatf("starve.stall%0d", k), 64'(stall_req), 64'(k == 5));
      cyc();
    end
    wb(1'b0, 5'd0, 32'h0);
    #1;
    chk_port("starve.r9", 1'b1, 5'd9, 32'h9999);
    chk("starve.stall_hold", 64'(stall_req), 64'h1);
    cyc();
    chk("starve.stall_clr", 64'(stall_req), 64'h0);
    chk("starve.busy_clr",  64'(busy_mask), 64'h0);

    // WAW kill of queued r10.
    mdu(1'b1, 5'd10, 32'h1010);
    cyc();
    mdu(1'b0, 5'd0, 32'h0);
    wb(1'b1, 5'd10, 32'hAAAA);
    #1;
    chk_port("waw.pipe", 1'b1, 5'd10, 32'hAAAA);
    chk("waw.busy_pre", 64'(busy_mask), 64'h400);
    cyc();
    wb(1'b0, 5'd0, 32'h0);
    chk("waw.busy_killed", 64'(busy_mask), 64'h0);
    #1;
    chk("waw.silent_pop", 64'(rf_we), 64'h0);
    cyc();
    chk("waw.after_we", 64'(rf_we), 64'h0);

    // Full / backpressure with the pipeline busy.
    wb(1'b1, 5'd3, 32'h0333);
    mdu(1'b1, 5'd11, 32'hB1);
    cyc();
    mdu(1'b1, 5'd12, 32'hB2);
    chk("full.ready1", 64'(mdu_ready), 64'h1);
    cyc();
    chk("full.ready0", 64'(mdu_ready), 64'h0);
    chk("full.busy2",  64'(busy_mask), 64'h1800);
    mdu(1'b1, 5'd13, 32'hB3);
    cyc();
    chk("full.held_ready", 64'(mdu_ready), 64'h0);
    chk("full.held_busy",  64'(busy_mask), 64'h1800);
    wb(1'b0, 5'd0, 32'h0);
    #1;
    chk_port("full.free_r11", 1'b1, 5'd11, 32'hB1);
    cyc();
    chk("full.ready_after", 64'(mdu_ready), 64'h1);
    chk("full.busy_r12",    64'(busy_mask), 64'h1000);
    #1;
    chk_port("full.pushpop_r12", 1'b1, 5'd12, 32'hB2);
    cyc();
    mdu(1'b0, 5'd0, 32'h0);
    chk("pushpop.busy",  64'(busy_mask), 64'h2000);
    chk("pushpop.ready", 64'(mdu_ready), 64'h1);
    #1;
    chk_port("pushpop.r13", 1'b1, 5'd13, 32'hB3);
    cyc();
    chk("pushpop.empty", 64'(rf_we), 64'h0);

    // $zero filtering.
    mdu(1'b1, 5'd0, 32'hDEAD);
    #1;
    chk("zero.ready", 64'(mdu_ready), 64'h1);
    cyc();
    mdu(1'b0, 5'd0, 32'h0);
    chk("zero.busy", 64'(busy_mask), 64'h0);
    chk("zero.nowrite", 64'(rf_we), 64'h0);
    mdu(1'b1, 5'd5, 32'h55);
    cyc();
    mdu(1'b0, 5'd0, 32'h0);
    wb(1'b1, 5'd0, 32'hBEEF);
    #1;
    chk_port("zero.wb_idle", 1'b1, 5'd5, 32'h55);
    cyc();
    wb(1'b0, 5'd0, 32'h0);
    chk("zero.drained", 64'(busy_mask), 64'h0);

    // Reset mid-operation with two entries queued.
    wb(1'b1, 5'd3, 32'h0333);
    mdu(1'b1, 5'd6, 32'h66);
    cyc();
    mdu(1'b1, 5'd7, 32'h77);
    cyc();
    mdu(1'b0, 5'd0, 32'h0);
    chk("mid.busy_pre",  64'(busy_mask), 64'hC0);
    chk("mid.ready_pre", 64'(mdu_ready), 64'h0);
    rst_n = 1'b0;
    #1;
    chk_port("mid.rst", 1'b0, 5'd0, 32'h0);
    chk("mid.busy",  64'(busy_mask), 64'h0);
    chk("mid.ready", 64'(mdu_ready), 64'h1);
    chk("mid.stall", 64'(stall_req), 64'h0);
    cyc();
    wb(1'b0, 5'd0, 32'h0);
    rst_n = 1'b1;
    #1;
    chk("mid.empty_we", 64'(rf_we), 64'h0);
    cyc();
    chk("mid.empty_busy", 64'(busy_mask), 64'h0);
    chk("mid.empty_we2",  64'(rf_we), 64'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
